// File: rtl/v4_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : v4_peak_detector
//  Description : Pulse peak detector for a shaped-filter sample stream.
//                A free-running timestamp tags every sample. When a sample
//                reaches the threshold, the block tracks the running maximum
//                and the time at which it occurred. When the pulse falls back
//                below the threshold, {amplitude, time, pileup} is pushed into
//                a show-ahead event FIFO. A dead-time of HOLDOFF samples then
//                follows. Records that arrive while the FIFO is full are
//                discarded and counted in a saturating drop counter.
//
//  Parameters  : DATA_W     - sample / threshold / amplitude width (signed)
//                TS_W       - timestamp counter width
//                HOLDOFF    - dead-time in samples after each pulse
//                FIFO_DEPTH - event FIFO depth (power of two, >= 2)
//
//  Ports       : clk        - clock, all inputs sampled on the rising edge
//                reset      - synchronous active-low reset
//                data_in    - signed shaped sample, one per cycle
//                threshold  - signed trigger level
//                evt_valid  - head record valid
//                evt_ready  - consumer accepts the head record
//                evt_amp    - head record peak amplitude
//                evt_time   - head record peak timestamp
//                evt_pileup - head record came from a retrigger in dead-time
//                drop_cnt   - saturating count of records lost to a full FIFO
//                busy       - detector is not idle
//
//  Options     : V4_PEAK_PILEUP_EN - when defined, a sample at or above the
//                threshold during dead-time restarts tracking and flags the
//                resulting record as pileup. When undefined, dead-time
//                samples are ignored and evt_pileup is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module v4_peak_detector #(
    parameter int DATA_W     = 32,
    parameter int TS_W       = 32,
    parameter int HOLDOFF    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] threshold,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_amp,
    output logic [TS_W-1:0]   evt_time,
    output logic              evt_pileup,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    // The hold counter only ever holds HOLDOFF-1 down to 0.
    localparam int c_HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [DATA_W-1:0] r_max;
    logic signed [DATA_W-1:0] w_max_nxt;
    logic [TS_W-1:0]          r_tmax;
    logic [TS_W-1:0]          w_tmax_nxt;
    logic [c_HW-1:0]          r_hold;
    logic [c_HW-1:0]          w_hold_nxt;
    logic [TS_W-1:0]          r_ts;
    logic                     w_push;
    logic                     w_ge_thr;
    logic                     w_gt_max;
`ifdef V4_PEAK_PILEUP_EN
    logic                     r_pile;
    logic                     w_pile_nxt;
`endif

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_W-1:0] r_mem_amp  [FIFO_DEPTH];
    logic [TS_W-1:0]   r_mem_time [FIFO_DEPTH];
`ifdef V4_PEAK_PILEUP_EN
    logic              r_mem_pile [FIFO_DEPTH];
`endif
    logic [c_AW:0]     r_wptr;
    logic [c_AW:0]     r_rptr;
    logic [15:0]       r_drop;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;

    assign w_ge_thr = ($signed(data_in) >= $signed(threshold));
    assign w_gt_max = ($signed(data_in) > r_max);

    // ------------------------------------------------------------------
    // Detector FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_max_nxt   = r_max;
        w_tmax_nxt  = r_tmax;
        w_hold_nxt  = r_hold;
        w_push      = 1'b0;
`ifdef V4_PEAK_PILEUP_EN
        w_pile_nxt  = r_pile;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_ge_thr) begin
                    w_state_nxt = S_TRACK;
                    w_max_nxt   = data_in;
                    w_tmax_nxt  = r_ts;
                end
            end
            S_TRACK: begin
                if (!w_ge_thr) begin
                    w_push = 1'b1;
`ifdef V4_PEAK_PILEUP_EN
                    w_pile_nxt = 1'b0;
`endif
                    if (HOLDOFF == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = c_HOLD_LOAD;
                    end
                end else if (w_gt_max) begin
                    // Strictly greater: on a plateau the first sample wins.
                    w_max_nxt  = data_in;
                    w_tmax_nxt = r_ts;
                end
            end
            S_HOLD: begin
`ifdef V4_PEAK_PILEUP_EN
                // A retrigger takes priority even on the last dead-time cycle.
                if (w_ge_thr) begin
                    w_state_nxt = S_TRACK;
                    w_max_nxt   = data_in;
                    w_tmax_nxt  = r_ts;
                    w_pile_nxt  = 1'b1;
                end else
`endif
                if (r_hold == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Detector FSM: state registers and timestamp
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_max   <= '0;
            r_tmax  <= '0;
            r_hold  <= '0;
            r_ts    <= '0;
`ifdef V4_PEAK_PILEUP_EN
            r_pile  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_max   <= w_max_nxt;
            r_tmax  <= w_tmax_nxt;
            r_hold  <= w_hold_nxt;
            r_ts    <= r_ts + 1'b1;
`ifdef V4_PEAK_PILEUP_EN
            r_pile  <= w_pile_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop   = !w_empty && evt_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset && w_wr) begin
            r_mem_amp[r_wptr[c_AW-1:0]]  <= r_max;
            r_mem_time[r_wptr[c_AW-1:0]] <= r_tmax;
`ifdef V4_PEAK_PILEUP_EN
            r_mem_pile[r_wptr[c_AW-1:0]] <= r_pile;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    // Head fields are forced to zero while the FIFO is empty so that stale
    // storage never shows on the outputs (including right after reset).
    assign evt_valid = !w_empty;
    assign evt_amp   = w_empty ? '0 : r_mem_amp[r_rptr[c_AW-1:0]];
    assign evt_time  = w_empty ? '0 : r_mem_time[r_rptr[c_AW-1:0]];
`ifdef V4_PEAK_PILEUP_EN
    assign evt_pileup = w_empty ? 1'b0 : r_mem_pile[r_rptr[c_AW-1:0]];
`else
    assign evt_pileup = 1'b0;
`endif
    assign drop_cnt  = r_drop;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_v4_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_v4_peak_detector
//  Description : Self-checking bench for v4_peak_detector. Two instances
//                (dead-time 4 and 8, 8-bit timestamp, depth-4 FIFO) share
//                one stimulus stream; a behavioural model per instance
//                predicts the outputs every cycle. Directed pulses pin
//                specific literal results, then a randomized run follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_v4_peak_detector;

    localparam int DW    = 16;
    localparam int TW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic [DW-1:0] threshold;
    logic          evt_ready;

    logic          vld  [2];
    logic [DW-1:0] amp  [2];
    logic [TW-1:0] tim  [2];
    logic          pile [2];
    logic [15:0]   drp  [2];
    logic          bsy  [2];

    int tests = 0;
    int fails = 0;

    v4_peak_detector #(.DATA_W(DW), .TS_W(TW), .HOLDOFF(4), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .threshold(threshold),
        .evt_valid(vld[0]), .evt_ready(evt_ready), .evt_amp(amp[0]), .evt_time(tim[0]),
        .evt_pileup(pile[0]), .drop_cnt(drp[0]), .busy(bsy[0])
    );

    v4_peak_detector #(.DATA_W(DW), .TS_W(TW), .HOLDOFF(8), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .threshold(threshold),
        .evt_valid(vld[1]), .evt_ready(evt_ready), .evt_amp(amp[1]), .evt_time(tim[1]),
        .evt_pileup(pile[1]), .drop_cnt(drp[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: a pulse is "being tracked" or not, followed by a
    // number of samples still to ignore; records sit in a list whose
    // element 0 is the head.
    // ------------------------------------------------------------------
    typedef struct {
        int amp;
        int tim;
        bit pile;
    } rec_t;

    rec_t mf    [2][DEPTH];
    int   m_cnt [2];
    bit   m_trk [2];
    int   m_ign [2];
    int   m_mx  [2];
    int   m_tmx [2];
    bit   m_pile[2];
    int   m_drop[2];
    int   m_ts;
    bit   started = 1'b0;

    rec_t log_a[$];
    rec_t log_b[$];

    function automatic int holdoff_of(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    task automatic model_reset(input int k);
        m_cnt[k]  = 0;
        m_trk[k]  = 1'b0;
        m_ign[k]  = 0;
        m_mx[k]   = 0;
        m_tmx[k]  = 0;
        m_pile[k] = 1'b0;
        m_drop[k] = 0;
    endtask

    task automatic model_step(input int k);
        int   d;
        int   t;
        bit   push;
        rec_t r;
        d    = int'($signed(data_in));
        t    = int'($signed(threshold));
        push = 1'b0;
        r.amp = 0; r.tim = 0; r.pile = 1'b0;
        if (m_ign[k] > 0) begin
`ifdef V4_PEAK_PILEUP_EN
            if (d >= t) begin
                m_trk[k]  = 1'b1;
                m_mx[k]   = d;
                m_tmx[k]  = m_ts;
                m_pile[k] = 1'b1;
                m_ign[k]  = 0;
            end else begin
                m_ign[k] = m_ign[k] - 1;
            end
`else
            m_ign[k] = m_ign[k] - 1;
`endif
        end else if (!m_trk[k]) begin
            if (d >= t) begin
                m_trk[k] = 1'b1;
                m_mx[k]  = d;
                m_tmx[k] = m_ts;
            end
        end else if (d < t) begin
            push      = 1'b1;
            r.amp     = m_mx[k];
            r.tim     = m_tmx[k];
            r.pile    = m_pile[k];
            m_trk[k]  = 1'b0;
            m_pile[k] = 1'b0;
            m_ign[k]  = holdoff_of(k);
        end else if (d > m_mx[k]) begin
            m_mx[k]  = d;
            m_tmx[k] = m_ts;
        end
        if (m_cnt[k] > 0 && evt_ready) begin
            for (int j = 0; j < DEPTH - 1; j++) mf[k][j] = mf[k][j+1];
            m_cnt[k] = m_cnt[k] - 1;
        end
        if (push) begin
            if (m_cnt[k] < DEPTH) begin
                mf[k][m_cnt[k]] = r;
                m_cnt[k] = m_cnt[k] + 1;
            end else if (m_drop[k] < 65535) begin
                m_drop[k] = m_drop[k] + 1;
            end
        end
    endtask

    always @(posedge clk) begin
        rec_t lr;
        if (started && reset) begin
            if (vld[0] && evt_ready) begin
                lr.amp = int'(amp[0]); lr.tim = int'(tim[0]); lr.pile = pile[0];
                log_a.push_back(lr);
            end
            if (vld[1] && evt_ready) begin
                lr.amp = int'(amp[1]); lr.tim = int'(tim[1]); lr.pile = pile[1];
                log_b.push_back(lr);
            end
        end
        if (!reset) begin
            model_reset(0);
            model_reset(1);
            m_ts    = 0;
            started = 1'b1;
        end else begin
            model_step(0);
            model_step(1);
            m_ts = (m_ts + 1) & 255;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic       ev;
                logic [DW-1:0] ea;
                logic [TW-1:0] et;
                logic       ep;
                bit         bad;
                ev  = (m_cnt[k] > 0);
                ea  = ev ? DW'(mf[k][0].amp) : amp[k];
                et  = ev ? TW'(mf[k][0].tim) : tim[k];
                ep  = ev ? mf[k][0].pile : pile[k];
                bad = (vld[k] !== ev) || (bsy[k] !== (m_trk[k] || m_ign[k] > 0)) ||
                      (drp[k] !== 16'(m_drop[k])) ||
                      (ev && ((amp[k] !== ea) || (tim[k] !== et) || (pile[k] !== ep)));
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL cycle_model dut%0d t=%0t: got v=%b a=%0d t=%0d p=%b d=%0d b=%b, want v=%b a=%0d t=%0d p=%b d=%0d b=%b",
                             k, $time, vld[k], amp[k], tim[k], pile[k], drp[k], bsy[k],
                             ev, ea, et, ep, m_drop[k], (m_trk[k] || m_ign[k] > 0));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_ts(input int n);
        int guard = 0;
        while (m_ts != n && guard < 600) begin
            tick();
            guard++;
        end
        tests++;
        if (guard >= 600) begin
            fails++;
            $display("FAIL wait_ts: timestamp %0d never reached, at %0d", n, m_ts);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int tv;
        bit rdy_mode;
        reset     = 1'b0;
        data_in   = '0;
        threshold = 16'd100;
        evt_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset valid",  32'(vld[k]),  0);
            chk("reset busy",   32'(bsy[k]),  0);
            chk("reset amp",    32'(amp[k]),  0);
            chk("reset time",   32'(tim[k]),  0);
            chk("reset pileup", 32'(pile[k]), 0);
            chk("reset drop",   32'(drp[k]),  0);
        end
        reset = 1'b1;

        // Basic pulse: peak 300 at ts=12, record visible right after sample 50.
        do_reset();
        data_in = '0; threshold = 16'd100; evt_ready = 1'b0;
        wait_ts(10);
        data_in = 16'd0;   tick();
        data_in = 16'd150; tick();
        data_in = 16'd300; tick();
        data_in = 16'd250; tick();
        chk("s1 not yet valid", 32'(vld[0]), 0);
        data_in = 16'd50;  tick();
        chk("s1 valid",        32'(vld[0]), 1);
        chk("s1 amp",          32'(amp[0]), 300);
        chk("s1 time",         32'(tim[0]), 12);
        chk("s1 pileup",       32'(pile[0]), 0);
        chk("s1 model amp",    32'(mf[0][0].amp), 300);
        chk("s1 model time",   32'(mf[0][0].tim), 12);
        data_in = 16'd0; repeat (3) tick();
        chk("s1 amp held",     32'(amp[0]), 300);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("s1 one record a", 32'(vld[0]), 0);
        chk("s1 one record b", 32'(vld[1]), 0);

        // Plateau: first maximum wins.
        do_reset();
        wait_ts(5);
        data_in = 16'd200; repeat (3) tick();
        data_in = 16'd0;   tick();
        chk("s2 time", 32'(tim[0]), 5);
        chk("s2 amp",  32'(amp[0]), 200);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // FIFO overflow: 6 pulses, 4 kept, 2 dropped, drained in order.
        do_reset();
        log_a.delete();
        for (int i = 0; i < 6; i++) begin
            data_in = 16'(110 + 20 * i); tick();
            data_in = 16'd0; repeat (11) tick();
        end
        chk("s3 drop a", 32'(drp[0]), 2);
        chk("s3 drop b", 32'(drp[1]), 2);
        chk("s3 head",   32'(amp[0]), 110);
        evt_ready = 1'b1; repeat (6) tick(); evt_ready = 1'b0;
        chk("s3 drained count", 32'(log_a.size()), 4);
        for (int i = 0; i < 4 && i < log_a.size(); i++)
            chk("s3 order", 32'(log_a[i].amp), 32'(110 + 20 * i));
        chk("s3 empty", 32'(vld[0]), 0);

        // Retrigger inside dead-time (instance b, HOLDOFF=8).
        do_reset();
        evt_ready = 1'b1;
        log_b.delete();
        repeat (3) tick();
        data_in = 16'd200; tick();
        data_in = 16'd0;   tick();
        tick(); tick();
        data_in = 16'd400; tick();
        data_in = 16'd0;   repeat (15) tick();
`ifdef V4_PEAK_PILEUP_EN
        chk("s4 records", 32'(log_b.size()), 2);
        if (log_b.size() == 2) begin
            chk("s4 amp1",  32'(log_b[0].amp), 200);
            chk("s4 pile1", 32'(log_b[0].pile), 0);
            chk("s4 amp2",  32'(log_b[1].amp), 400);
            chk("s4 pile2", 32'(log_b[1].pile), 1);
        end
`else
        chk("s4 records", 32'(log_b.size()), 1);
        if (log_b.size() == 1) begin
            chk("s4 amp1",  32'(log_b[0].amp), 200);
            chk("s4 pile1", 32'(log_b[0].pile), 0);
        end
`endif
        evt_ready = 1'b0;

        // Reset during tracking discards the pulse.
        do_reset();
        data_in = 16'd0; tick();
        data_in = 16'd500; tick(); tick();
        chk("s5 tracking", 32'(bsy[0]), 1);
        reset = 1'b0; tick(); reset = 1'b1;
        data_in = 16'd0;
        chk("s5 busy",  32'(bsy[0]), 0);
        chk("s5 drop",  32'(drp[0]), 0);
        chk("s5 valid", 32'(vld[0]), 0);
        repeat (5) tick();
        chk("s5 no record", 32'(vld[0]), 0);

        // Timestamp wrap: larger peak after wrap wins.
        do_reset();
        data_in = 16'd0;
        wait_ts(255);
        data_in = 16'd300; tick();
        data_in = 16'd200; tick();
        data_in = 16'd400; tick();
        data_in = 16'd0;   tick();
        chk("s6 time", 32'(tim[0]), 1);
        chk("s6 amp",  32'(amp[0]), 400);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // Randomized run.
        tv = 100;
        rdy_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: tv = 100;
                    1: tv = -50;
                    2: tv = 0;
                    default: tv = -32000;
                endcase
                threshold = 16'(tv);
            end
            if (c % 97 == 0) rdy_mode = ~rdy_mode;
            v = tv + int'($urandom_range(0, 400)) - 200;
            if ($urandom_range(0, 49) == 0) v = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            data_in   = 16'(v);
            evt_ready = rdy_mode && ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset = 1'b1;
        evt_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
